// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: widths, bubble instruction and one-hot opcode indices.
// Also provides the x0 write-enable gate used by every stage that latches rd.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int OH_W = 7;

    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    localparam logic [OH_W-1:0] OH_NOP   = 7'd0;
    localparam logic [OH_W-1:0] OH_LUI   = 7'd1;
    localparam logic [OH_W-1:0] OH_AUIPC = 7'd2;
    localparam logic [OH_W-1:0] OH_JAL   = 7'd3;
    localparam logic [OH_W-1:0] OH_JALR  = 7'd4;
    localparam logic [OH_W-1:0] OH_BEQ   = 7'd5;
    localparam logic [OH_W-1:0] OH_BNE   = 7'd6;
    localparam logic [OH_W-1:0] OH_BLT   = 7'd7;
    localparam logic [OH_W-1:0] OH_BGE   = 7'd8;
    localparam logic [OH_W-1:0] OH_BLTU  = 7'd9;
    localparam logic [OH_W-1:0] OH_BGEU  = 7'd10;
    localparam logic [OH_W-1:0] OH_LB    = 7'd11;
    localparam logic [OH_W-1:0] OH_LH    = 7'd12;
    localparam logic [OH_W-1:0] OH_LW    = 7'd13;
    localparam logic [OH_W-1:0] OH_LBU   = 7'd14;
    localparam logic [OH_W-1:0] OH_LHU   = 7'd15;
    localparam logic [OH_W-1:0] OH_SB    = 7'd16;
    localparam logic [OH_W-1:0] OH_SH    = 7'd17;
    localparam logic [OH_W-1:0] OH_SW    = 7'd18;
    localparam logic [OH_W-1:0] OH_ADDI  = 7'd19;
    localparam logic [OH_W-1:0] OH_SLTI  = 7'd20;
    localparam logic [OH_W-1:0] OH_SLTIU = 7'd21;
    localparam logic [OH_W-1:0] OH_XORI  = 7'd22;
    localparam logic [OH_W-1:0] OH_ORI   = 7'd23;
    localparam logic [OH_W-1:0] OH_ANDI  = 7'd24;
    localparam logic [OH_W-1:0] OH_SLLI  = 7'd25;
    localparam logic [OH_W-1:0] OH_SRLI  = 7'd26;
    localparam logic [OH_W-1:0] OH_SRAI  = 7'd27;
    localparam logic [OH_W-1:0] OH_ADD   = 7'd28;
    localparam logic [OH_W-1:0] OH_SUB   = 7'd29;
    localparam logic [OH_W-1:0] OH_SLL   = 7'd30;
    localparam logic [OH_W-1:0] OH_SLT   = 7'd31;
    localparam logic [OH_W-1:0] OH_SLTU  = 7'd32;
    localparam logic [OH_W-1:0] OH_XOR   = 7'd33;
    localparam logic [OH_W-1:0] OH_SRL   = 7'd34;
    localparam logic [OH_W-1:0] OH_SRA   = 7'd35;
    localparam logic [OH_W-1:0] OH_OR    = 7'd36;
    localparam logic [OH_W-1:0] OH_AND   = 7'd37;

    // x0 is hard-wired zero, so a write to it must never be enabled.
    function automatic logic rd_wen_gate(input logic wen, input logic [4:0] addr);
        return wen && (addr != 5'd0);
    endfunction

endpackage

// File: rtl/id_ex_reg_fwd_mux.sv
// Operand forward select: replaces a reg-file operand with execute's write-back data on a match.
// Only compiled when ID_EX_FWD_EN is defined.
`ifdef ID_EX_FWD_EN
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] op_i,
    input  logic            op_is_rs_i,
    input  logic [4:0]      rs_addr_i,
    input  logic            ex_rd_wen_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [XLEN-1:0] ex_rd_data_i,
    output logic [XLEN-1:0] op_o
);

    logic w_hit;

    assign w_hit = op_is_rs_i && ex_rd_wen_i && (ex_rd_addr_i != 5'd0)
                   && (ex_rd_addr_i == rs_addr_i);
    assign op_o  = w_hit ? ex_rd_data_i : op_i;

endmodule
`endif

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with flush (bubble) over hold (stall) over capture.
// Define ID_EX_FWD_EN to forward execute's write-back into the captured operands.
module id_ex_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ins_i,
    input  logic [XLEN-1:0] ins_addr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rs1_addr_i,
    input  logic [4:0]      rs2_addr_i,
    input  logic            op1_is_rs_i,
    input  logic            op2_is_rs_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    input  logic [OH_W-1:0] oh_i,
    input  logic            hold_i,
    input  logic            flush_i,
    input  logic [4:0]      ex_rd_addr_i,
    input  logic [XLEN-1:0] ex_rd_data_i,
    input  logic            ex_rd_wen_i,
    output logic [XLEN-1:0] ins_o,
    output logic [XLEN-1:0] ins_addr_o,
    output logic [XLEN-1:0] op1_o,
    output logic [XLEN-1:0] op2_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o,
    output logic [OH_W-1:0] oh_o,
    output logic            valid_o
);

    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    logic [XLEN-1:0] r_ins;
    logic [XLEN-1:0] r_ins_addr;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [4:0]      r_rd_addr;
    logic            r_rd_wen;
    logic [OH_W-1:0] r_oh;
    logic            r_valid;

`ifdef ID_EX_FWD_EN
    fwd_mux u_fwd_op1 (
        .op_i         (op1_i),
        .op_is_rs_i   (op1_is_rs_i),
        .rs_addr_i    (rs1_addr_i),
        .ex_rd_wen_i  (ex_rd_wen_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .op_o         (w_op1)
    );

    fwd_mux u_fwd_op2 (
        .op_i         (op2_i),
        .op_is_rs_i   (op2_is_rs_i),
        .rs_addr_i    (rs2_addr_i),
        .ex_rd_wen_i  (ex_rd_wen_i),
        .ex_rd_addr_i (ex_rd_addr_i),
        .ex_rd_data_i (ex_rd_data_i),
        .op_o         (w_op2)
    );
`else
    // Forward inputs stay on the port list so decode wiring is identical in both builds.
    logic w_unused_fwd;

    assign w_unused_fwd = ^{rs1_addr_i, rs2_addr_i, op1_is_rs_i, op2_is_rs_i,
                            ex_rd_addr_i, ex_rd_data_i, ex_rd_wen_i};
    assign w_op1 = op1_i;
    assign w_op2 = op2_i;
`endif

    // Stage register bank: bubble on flush, keep on hold, otherwise capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ins      <= NOP_INS;
            r_ins_addr <= 32'd0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_rd_addr  <= 5'd0;
            r_rd_wen   <= 1'b0;
            r_oh       <= OH_NOP;
            r_valid    <= 1'b0;
        end else if (flush_i) begin
            r_ins      <= NOP_INS;
            r_ins_addr <= 32'd0;
            r_op1      <= 32'd0;
            r_op2      <= 32'd0;
            r_rd_addr  <= 5'd0;
            r_rd_wen   <= 1'b0;
            r_oh       <= OH_NOP;
            r_valid    <= 1'b0;
        end else if (hold_i) begin
            r_ins      <= r_ins;
            r_ins_addr <= r_ins_addr;
            r_op1      <= r_op1;
            r_op2      <= r_op2;
            r_rd_addr  <= r_rd_addr;
            r_rd_wen   <= r_rd_wen;
            r_oh       <= r_oh;
            r_valid    <= r_valid;
        end else begin
            r_ins      <= ins_i;
            r_ins_addr <= ins_addr_i;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_rd_addr  <= rd_addr_i;
            r_rd_wen   <= rd_wen_gate(rd_wen_i, rd_addr_i);
            r_oh       <= oh_i;
            r_valid    <= 1'b1;
        end
    end

    assign ins_o      = r_ins;
    assign ins_addr_o = r_ins_addr;
    assign op1_o      = r_op1;
    assign op2_o      = r_op2;
    assign rd_addr_o  = r_rd_addr;
    assign rd_wen_o   = r_rd_wen;
    assign oh_o       = r_oh;
    assign valid_o    = r_valid;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: expected stage contents are queued as each edge is driven.
// Forwarding expectations follow ID_EX_FWD_EN.
module tb_id_ex_reg;
    import riscv_pkg::*;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] addr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd_addr;
        logic        rd_wen;
        logic [6:0]  oh;
        logic        valid;
    } outs_t;

    localparam outs_t BUBBLE = '{ins: 32'h0000_0013, addr: 32'd0, op1: 32'd0, op2: 32'd0,
                                 rd_addr: 5'd0, rd_wen: 1'b0, oh: 7'd0, valid: 1'b0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ins_i = 32'd0, ins_addr_i = 32'd0, op1_i = 32'd0, op2_i = 32'd0;
    logic [4:0]  rs1_addr_i = 5'd0, rs2_addr_i = 5'd0, rd_addr_i = 5'd0, ex_rd_addr_i = 5'd0;
    logic        op1_is_rs_i = 1'b0, op2_is_rs_i = 1'b0, rd_wen_i = 1'b0;
    logic [6:0]  oh_i = 7'd0;
    logic        hold_i = 1'b0, flush_i = 1'b0, ex_rd_wen_i = 1'b0;
    logic [31:0] ex_rd_data_i = 32'd0;
    logic [31:0] ins_o, ins_addr_o, op1_o, op2_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o, valid_o;
    logic [6:0]  oh_o;

    outs_t obs;
    outs_t mdl;
    outs_t exp_q[$];
    outs_t exp_v;
    int checks = 0;
    int errors = 0;

    id_ex_reg dut (
        .clk(clk), .rst_n(rst_n), .ins_i(ins_i), .ins_addr_i(ins_addr_i),
        .op1_i(op1_i), .op2_i(op2_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .op1_is_rs_i(op1_is_rs_i), .op2_is_rs_i(op2_is_rs_i), .rd_addr_i(rd_addr_i),
        .rd_wen_i(rd_wen_i), .oh_i(oh_i), .hold_i(hold_i), .flush_i(flush_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_rd_data_i(ex_rd_data_i), .ex_rd_wen_i(ex_rd_wen_i),
        .ins_o(ins_o), .ins_addr_o(ins_addr_o), .op1_o(op1_o), .op2_o(op2_o),
        .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o), .oh_o(oh_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    assign obs = {ins_o, ins_addr_o, op1_o, op2_o, rd_addr_o, rd_wen_o, oh_o, valid_o};

    function automatic logic [31:0] fwd(input logic [31:0] op, input logic is_rs,
                                        input logic [4:0] rs);
`ifdef ID_EX_FWD_EN
        if (is_rs && ex_rd_wen_i && ex_rd_addr_i != 5'd0 && ex_rd_addr_i == rs)
            return ex_rd_data_i;
`endif
        return op;
    endfunction

    // Predict the next stage contents from the current inputs, queue it, then clock.
    task automatic step();
        outs_t n;
        if (flush_i) n = BUBBLE;
        else if (hold_i) n = mdl;
        else begin
            n.ins = ins_i; n.addr = ins_addr_i;
            n.op1 = fwd(op1_i, op1_is_rs_i, rs1_addr_i);
            n.op2 = fwd(op2_i, op2_is_rs_i, rs2_addr_i);
            n.rd_addr = rd_addr_i; n.rd_wen = rd_wen_i && (rd_addr_i != 5'd0);
            n.oh = oh_i; n.valid = 1'b1;
        end
        mdl = n;
        exp_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== BUBBLE) begin
            errors++; $display("FAIL reset: got %h want %h", obs, BUBBLE);
        end
        rst_n = 1'b1;
        mdl = BUBBLE;
    endtask

    task automatic test_capture();
        ins_i = 32'h0050_0093; ins_addr_i = 32'h0000_0100; op1_i = 32'd0; op2_i = 32'd5;
        oh_i = 7'd19; rd_addr_i = 5'd1; rd_wen_i = 1'b1;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL capture: got %h want %h", obs, exp_v);
        end
        checks++;
        if (ins_o !== 32'h0050_0093 || op2_o !== 32'd5 || oh_o !== 7'd19 ||
            rd_wen_o !== 1'b1 || valid_o !== 1'b1) begin
            errors++; $display("FAIL capture_fields: ins %h op2 %h oh %0d wen %b valid %b",
                               ins_o, op2_o, oh_o, rd_wen_o, valid_o);
        end
    endtask

    task automatic test_hold();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins_i = 32'hdead_0000 + i; op1_i = 32'h111 * (i + 1); oh_i = 7'd28 + 7'(i);
            rd_addr_i = 5'd7 + 5'(i);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v || ins_o !== 32'h0050_0093 || valid_o !== 1'b1) begin
                errors++; $display("FAIL hold_%0d: got %h want %h", i, obs, exp_v);
            end
        end
        hold_i = 1'b0;
    endtask

    task automatic test_flush();
        flush_i = 1'b1; hold_i = 1'b1;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || oh_o !== 7'd0 || rd_wen_o !== 1'b0 ||
            ins_o !== 32'h0000_0013 || valid_o !== 1'b0) begin
            errors++; $display("FAIL flush: got %h want %h", obs, exp_v);
        end
        flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic test_x0();
        ins_i = 32'h0010_0013; rd_addr_i = 5'd0; rd_wen_i = 1'b1; oh_i = 7'd19;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || rd_wen_o !== 1'b0 || valid_o !== 1'b1) begin
            errors++; $display("FAIL x0_wen: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_fwd();
        logic [31:0] want;
        rs1_addr_i = 5'd3; op1_is_rs_i = 1'b1; op1_i = 32'd7; rd_addr_i = 5'd4;
        ex_rd_wen_i = 1'b1; ex_rd_addr_i = 5'd3; ex_rd_data_i = 32'h55;
`ifdef ID_EX_FWD_EN
        want = 32'h55;
`else
        want = 32'd7;
`endif
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || op1_o !== want) begin
            errors++; $display("FAIL fwd_hit: op1 %h want %h", op1_o, want);
        end
        ex_rd_addr_i = 5'd0;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v || op1_o !== 32'd7) begin
            errors++; $display("FAIL fwd_x0: op1 %h want %h", op1_o, 32'd7);
        end
        ex_rd_wen_i = 1'b0; op1_is_rs_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            ins_i = $urandom; ins_addr_i = $urandom; op1_i = $urandom; op2_i = $urandom;
            rs1_addr_i = 5'($urandom_range(0, 3)); rs2_addr_i = 5'($urandom_range(0, 3));
            op1_is_rs_i = 1'($urandom); op2_is_rs_i = 1'($urandom);
            rd_addr_i = 5'($urandom_range(0, 31)); rd_wen_i = 1'($urandom);
            oh_i = 7'($urandom_range(0, 37));
            ex_rd_addr_i = 5'($urandom_range(0, 3)); ex_rd_wen_i = 1'($urandom);
            ex_rd_data_i = $urandom;
            hold_i = ($urandom_range(0, 3) == 0); flush_i = ($urandom_range(0, 5) == 0);
            step();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL b2b_%0d: got %h want %h", i, obs, exp_v);
            end
        end
        hold_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_async_reset();
        ins_i = 32'h0000_00b3; oh_i = 7'd28; rd_addr_i = 5'd2; rd_wen_i = 1'b1;
        step();
        exp_v = exp_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL pre_rst: got %h want %h", obs, exp_v);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== BUBBLE) begin
            errors++; $display("FAIL async_rst: got %h want %h", obs, BUBBLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        mdl = BUBBLE;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_hold();
        test_flush();
        test_x0();
        test_fwd();
        test_back_to_back();
        test_async_reset();
        test_capture();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
